// File: rtl/sortnet_pkg.sv
// sortnet_pkg: types, defaults and helpers shared by the sorting-network stages.
//   merge_state_e : merge FSM states
//   DEF_DATW/KEYW/CNTW : default element, key and run-length counter widths
//   key_extract() : unsigned key taken from the low bits of an element
package sortnet_pkg;

  localparam int unsigned DEF_DATW = 128;
  localparam int unsigned DEF_KEYW = 32;
  localparam int unsigned DEF_CNTW = 16;

  // Widest key any stage may use; keys are compared at this width with the
  // bits above the stage's KEYW zeroed, which synthesis prunes away.
  localparam int unsigned MAX_KEYW = 256;

  typedef enum logic [2:0] {
    StIdle,
    StMerge,
    StDrainA,
    StDrainB,
    StDone
  } merge_state_e;

  // Keeps the low keyw bits of the element, zero above.
  function automatic logic [MAX_KEYW-1:0] key_extract(input logic [MAX_KEYW-1:0] low_bits,
                                                      input int unsigned keyw);
    logic [MAX_KEYW-1:0] key;
    key = '0;
    for (int unsigned i = 0; i < MAX_KEYW; i++) begin
      if (i < keyw) key[i] = low_bits[i];
    end
    return key;
  endfunction

endpackage

// File: rtl/merge_out_reg.sv
// merge_out_reg: single-entry registered valid/ready output stage.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_load              : capture i_data/i_last; caller only loads when the
//                         register is empty or being drained this cycle
//   i_data, i_last      : element and end-of-run flag to capture
//   i_ready             : downstream accept
//   o_data/o_last/o_valid : registered stream output
module merge_out_reg #(
  parameter int unsigned DATW = 128
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [DATW-1:0] i_data,
  input  logic            i_last,
  input  logic            i_ready,
  output logic [DATW-1:0] o_data,
  output logic            o_last,
  output logic            o_valid
);

  logic [DATW-1:0] r_data;
  logic            r_last;
  logic            r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      // Accepted (or already empty): data is left as-is, only the flags clear.
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_valid = r_valid;

endmodule

// File: rtl/merge_2way_sorted.sv
// merge_2way_sorted: merges two ascending runs of i_run_len elements each, read
// from two show-ahead FIFOs, into one ascending run on a valid/ready stream.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_start, i_run_len           : start pulse and per-input run length (0 ok)
//   o_busy, o_done               : merge in progress / one-cycle completion pulse
//   i_a_data, i_a_empty, o_a_rd_en : FIFO A head, empty flag, pop
//   i_b_data, i_b_empty, o_b_rd_en : FIFO B head, empty flag, pop
//   o_data, o_valid, o_last, i_ready : merged output stream
// Ties pop A first, so the merge is stable. KEYW must not exceed MAX_KEYW.
module merge_2way_sorted
  import sortnet_pkg::*;
#(
  parameter int unsigned DATW = DEF_DATW,
  parameter int unsigned KEYW = DEF_KEYW,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [CNTW-1:0] i_run_len,
  output logic            o_busy,
  output logic            o_done,
  input  logic [DATW-1:0] i_a_data,
  input  logic            i_a_empty,
  output logic            o_a_rd_en,
  input  logic [DATW-1:0] i_b_data,
  input  logic            i_b_empty,
  output logic            o_b_rd_en,
  output logic [DATW-1:0] o_data,
  output logic            o_valid,
  output logic            o_last,
  input  logic            i_ready
);

  merge_state_e r_state;
  merge_state_e w_state_next;

  logic [CNTW-1:0] r_rem_a;
  logic [CNTW-1:0] r_rem_b;
  logic            r_done;

  logic                w_adv;
  logic                w_pop_a;
  logic                w_pop_b;
  logic                w_last;
  logic                w_a_le_b;
  logic                w_rem_a_one;
  logic                w_rem_b_one;
  logic [MAX_KEYW-1:0] w_key_a;
  logic [MAX_KEYW-1:0] w_key_b;
  logic [DATW-1:0]     w_load_data;

  // Output register can take a new element this cycle.
  assign w_adv = ~o_valid | i_ready;

  assign w_key_a  = key_extract(MAX_KEYW'(i_a_data), KEYW);
  assign w_key_b  = key_extract(MAX_KEYW'(i_b_data), KEYW);
  assign w_a_le_b = (w_key_a <= w_key_b);

  assign w_rem_a_one = (r_rem_a == CNTW'(1));
  assign w_rem_b_one = (r_rem_b == CNTW'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_run_len == '0) ? StDone : StMerge;
        end
      end
      StMerge: begin
        // The drain target is the input that still has elements left.
        if (w_pop_a && w_rem_a_one) begin
          w_state_next = StDrainB;
        end else if (w_pop_b && w_rem_b_one) begin
          w_state_next = StDrainA;
        end
      end
      StDrainA: begin
        if (w_pop_a && w_rem_a_one) w_state_next = StDone;
      end
      StDrainB: begin
        if (w_pop_b && w_rem_b_one) w_state_next = StDone;
      end
      StDone: begin
        // Output register is empty or its last element is being taken now.
        if (w_adv) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic: pop selection, read enables, busy, last flag
  always_comb begin
    w_pop_a = 1'b0;
    w_pop_b = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      StMerge: begin
        if (w_adv && !i_a_empty && !i_b_empty) begin
          w_pop_a = w_a_le_b;
          w_pop_b = ~w_a_le_b;
        end
      end
      StDrainA: begin
        w_pop_a = w_adv && !i_a_empty && (r_rem_a != '0);
        w_last  = w_rem_a_one;
      end
      StDrainB: begin
        w_pop_b = w_adv && !i_b_empty && (r_rem_b != '0);
        w_last  = w_rem_b_one;
      end
      default: ;
    endcase
    o_a_rd_en = w_pop_a & ~i_rst;
    o_b_rd_en = w_pop_b & ~i_rst;
    o_busy    = (r_state != StIdle);
  end

  // Remaining-element counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem_a <= '0;
      r_rem_b <= '0;
    end else if (r_state == StIdle) begin
      if (i_start) begin
        r_rem_a <= i_run_len;
        r_rem_b <= i_run_len;
      end
    end else begin
      if (w_pop_a) r_rem_a <= r_rem_a - CNTW'(1);
      if (w_pop_b) r_rem_b <= r_rem_b - CNTW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StDone) && w_adv;
    end
  end

  assign o_done = r_done;

  assign w_load_data = w_pop_a ? i_a_data : i_b_data;

  merge_out_reg #(
    .DATW(DATW)
  ) u_out_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_pop_a | w_pop_b),
    .i_data (w_load_data),
    .i_last (w_last),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_last (o_last),
    .o_valid(o_valid)
  );

endmodule

// File: tb/tb_merge_2way_sorted.sv
// tb_merge_2way_sorted: directed self-checking bench for merge_2way_sorted.
// FIFOs are modelled as queues whose head and empty flag update on the falling
// edge after a sampled pop; stimulus changes 1 time unit after a falling edge.
module tb_merge_2way_sorted;

  localparam int unsigned DATW = 128;
  localparam int unsigned KEYW = 32;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [CNTW-1:0] i_run_len = '0;
  logic            o_busy;
  logic            o_done;
  logic [DATW-1:0] i_a_data = '0;
  logic            i_a_empty = 1'b1;
  logic            o_a_rd_en;
  logic [DATW-1:0] i_b_data = '0;
  logic            i_b_empty = 1'b1;
  logic            o_b_rd_en;
  logic [DATW-1:0] o_data;
  logic            o_valid;
  logic            o_last;
  logic            i_ready = 1'b1;

  always #5 clk = ~clk;

  merge_2way_sorted #(
    .DATW(DATW),
    .KEYW(KEYW),
    .CNTW(CNTW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_run_len(i_run_len),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .i_a_data (i_a_data),
    .i_a_empty(i_a_empty),
    .o_a_rd_en(o_a_rd_en),
    .i_b_data (i_b_data),
    .i_b_empty(i_b_empty),
    .o_b_rd_en(o_b_rd_en),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .i_ready  (i_ready)
  );

  logic [DATW-1:0] qa[$];
  logic [DATW-1:0] qb[$];
  bit              hold_b = 1'b0;
  bit              bp_mode = 1'b0;
  int              phase = 0;
  bit              pend_a = 1'b0;
  bit              pend_b = 1'b0;

  logic [DATW-1:0] beat_d[$];
  logic            beat_l[$];
  int              beat_c[$];
  int              cyc = 0;
  int              start_cyc = 0;
  int              done_cyc = 0;
  int              done_cnt = 0;
  logic            done_busy = 1'b0;
  int              b_pops = 0;
  int              viol_empty = 0;
  int              stall_pop = 0;
  int              stall_chg = 0;
  logic            prev_stall = 1'b0;
  logic [DATW-1:0] prev_data = '0;
  logic            prev_last = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model and ready pattern (1,0,0,1 repeating under backpressure)
  always @(negedge clk) begin
    if (pend_a && qa.size() > 0) void'(qa.pop_front());
    if (pend_b && qb.size() > 0) void'(qb.pop_front());
    i_a_empty = (qa.size() == 0);
    i_a_data  = (qa.size() == 0) ? '0 : qa[0];
    i_b_empty = (qb.size() == 0) || hold_b;
    i_b_data  = (qb.size() == 0) ? '0 : qb[0];
    if (bp_mode) begin
      i_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      phase++;
    end else begin
      i_ready = 1'b1;
    end
  end

  // Monitor: pops, handshakes, done pulses, protocol violations
  always @(posedge clk) begin
    pend_a = o_a_rd_en;
    pend_b = o_b_rd_en;
    if (o_b_rd_en) b_pops++;
    if ((o_a_rd_en && i_a_empty) || (o_b_rd_en && i_b_empty)) viol_empty++;
    if (o_valid && !i_ready && (o_a_rd_en || o_b_rd_en)) stall_pop++;
    if (prev_stall && (o_data !== prev_data || o_last !== prev_last)) stall_chg++;
    prev_stall = o_valid && !i_ready && !i_rst;
    prev_data  = o_data;
    prev_last  = o_last;
    if (i_start && !i_rst) start_cyc = cyc;
    if (o_valid && i_ready && !i_rst) begin
      beat_d.push_back(o_data);
      beat_l.push_back(o_last);
      beat_c.push_back(cyc);
    end
    if (o_done) begin
      done_cyc  = cyc;
      done_busy = o_busy;
      done_cnt++;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [DATW-1:0] got,
                       input logic [DATW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DATW-1:0] el(input logic [15:0] tag, input logic [31:0] key);
    return {80'h0, tag, key};
  endfunction

  task automatic start_merge(input int len);
    i_run_len = CNTW'(len);
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
    check("busy_after_start", DATW'(o_busy), DATW'(1));
  endtask

  task automatic wait_done(input int base_cnt);
    int n;
    n = 0;
    while (done_cnt == base_cnt && n < 300) begin
      tick();
      n++;
    end
    check("done_timeout", DATW'(done_cnt != base_cnt), DATW'(1));
  endtask

  task automatic wait_beats(input int count);
    int n;
    n = 0;
    while (beat_d.size() < count && n < 100) begin
      tick();
      n++;
    end
    check("beat_timeout", DATW'(beat_d.size() >= count), DATW'(1));
  endtask

  task automatic check_beats(input string name, input int base, input logic [DATW-1:0] exp[$]);
    check({name, "_count"}, DATW'(beat_d.size() - base), DATW'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < beat_d.size()) begin
        check($sformatf("%s_data%0d", name, i), beat_d[base+i], exp[i]);
        check($sformatf("%s_last%0d", name, i), DATW'(beat_l[base+i]),
              DATW'(i == exp.size() - 1));
      end
    end
  endtask

  task automatic load_basic();
    qa = {el(16'hA, 1), el(16'hA, 3), el(16'hA, 5), el(16'hA, 7)};
    qb = {el(16'hB, 2), el(16'hB, 4), el(16'hB, 6), el(16'hB, 8)};
    tick();
  endtask

  initial begin
    logic [DATW-1:0] exp_basic[$];
    logic [DATW-1:0] exp[$];
    int b0, d0, n0, p0;

    exp_basic = {el(16'hA, 1), el(16'hB, 2), el(16'hA, 3), el(16'hB, 4),
                 el(16'hA, 5), el(16'hB, 6), el(16'hA, 7), el(16'hB, 8)};

    // Reset state
    repeat (3) tick();
    check("rst_valid", DATW'(o_valid), DATW'(0));
    check("rst_data", o_data, '0);
    check("rst_last", DATW'(o_last), DATW'(0));
    check("rst_done", DATW'(o_done), DATW'(0));
    check("rst_busy", DATW'(o_busy), DATW'(0));
    check("rst_rd_en", DATW'({o_a_rd_en, o_b_rd_en}), DATW'(0));
    i_rst = 1'b0;
    tick();

    // Basic merge at full throughput
    load_basic();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(4);
    wait_done(d0);
    check_beats("basic", b0, exp_basic);
    if (beat_d.size() >= b0 + 8) begin
      check("basic_first_latency", DATW'(beat_c[b0] - start_cyc), DATW'(2));
      check("basic_back_to_back", DATW'(beat_c[b0+7] - beat_c[b0]), DATW'(7));
      check("basic_done_latency", DATW'(done_cyc - beat_c[b0+7]), DATW'(1));
    end
    check("basic_busy_at_done", DATW'(done_busy), DATW'(0));
    tick();
    check("basic_done_pulse", DATW'(done_cnt - d0), DATW'(1));

    // Tie stability, B drains after A runs out
    qa = {el(16'hA0, 5), el(16'hA1, 5)};
    qb = {el(16'hB0, 5), el(16'hB9, 9)};
    tick();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(2);
    wait_done(d0);
    exp = {el(16'hA0, 5), el(16'hA1, 5), el(16'hB0, 5), el(16'hB9, 9)};
    check_beats("tie", b0, exp);

    // Backpressure
    bp_mode = 1'b1;
    load_basic();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(4);
    wait_done(d0);
    bp_mode = 1'b0;
    check_beats("bp", b0, exp_basic);

    // B empty for 10 cycles mid-run
    load_basic();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(4);
    wait_beats(b0 + 3);
    hold_b = 1'b1;
    tick();
    tick();
    n0 = beat_d.size();
    p0 = b_pops;
    repeat (10) tick();
    check("gap_no_output", DATW'(beat_d.size()), DATW'(n0));
    check("gap_no_b_pop", DATW'(b_pops), DATW'(p0));
    hold_b = 1'b0;
    wait_done(d0);
    check_beats("gap", b0, exp_basic);

    // Zero-length run
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(0);
    wait_done(d0);
    check("zero_done_latency", DATW'(done_cyc - start_cyc), DATW'(2));
    check("zero_no_beats", DATW'(beat_d.size()), DATW'(b0));

    // Surplus FIFO content stays behind
    qa = {el(16'hA, 10), el(16'hA, 20), el(16'hA, 30)};
    qb = {el(16'hB, 15), el(16'hB, 25), el(16'hB, 35)};
    tick();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(2);
    wait_done(d0);
    repeat (2) tick();
    exp = {el(16'hA, 10), el(16'hB, 15), el(16'hA, 20), el(16'hB, 25)};
    check_beats("extra", b0, exp);
    check("extra_a_left", DATW'(qa.size()), DATW'(1));
    check("extra_b_left", DATW'(qb.size()), DATW'(1));
    if (qa.size() > 0) check("extra_a_head", qa[0], el(16'hA, 30));
    if (qb.size() > 0) check("extra_b_head", qb[0], el(16'hB, 35));
    qa.delete();
    qb.delete();
    tick();

    // Reset mid-run, then a fresh merge that drains A
    load_basic();
    b0 = beat_d.size();
    start_merge(4);
    wait_beats(b0 + 3);
    i_rst = 1'b1;
    tick();
    check("midrst_valid", DATW'(o_valid), DATW'(0));
    check("midrst_data", o_data, '0);
    check("midrst_last", DATW'(o_last), DATW'(0));
    check("midrst_busy", DATW'(o_busy), DATW'(0));
    check("midrst_done", DATW'(o_done), DATW'(0));
    check("midrst_rd_en", DATW'({o_a_rd_en, o_b_rd_en}), DATW'(0));
    i_rst = 1'b0;
    qa.delete();
    qb.delete();
    tick();
    qa = {el(16'hA, 11), el(16'hA, 12), el(16'hA, 13)};
    qb = {el(16'hB, 1), el(16'hB, 2), el(16'hB, 3)};
    tick();
    b0 = beat_d.size();
    d0 = done_cnt;
    start_merge(3);
    wait_done(d0);
    exp = {el(16'hB, 1), el(16'hB, 2), el(16'hB, 3),
           el(16'hA, 11), el(16'hA, 12), el(16'hA, 13)};
    check_beats("after_rst", b0, exp);

    // Protocol invariants over the whole run
    check("pop_while_empty", DATW'(viol_empty), DATW'(0));
    check("pop_while_stalled", DATW'(stall_pop), DATW'(0));
    check("stall_output_change", DATW'(stall_chg), DATW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
